// File: rtl/msx_wait_pkg.sv
// Shared types for the MSX Z80 wait-state generator.
//   wait_state_t : FSM states (idle, counting, external extension, hold-to-end-of-cycle)
//   cyc_typ_t    : bus cycle classification
//   iowin_cfg_t  : one I/O wait window (base port, compare mask, wait count, enable)
//   port_match() : masked 8-bit I/O port compare
package msx_wait_pkg;

  // Widest wait-count field an I/O window can carry; CNT_W must not exceed this.
  localparam int unsigned MaxCntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StExt,
    StHold
  } wait_state_t;

  typedef enum logic [1:0] {
    CycNone,
    CycFetch,
    CycMem,
    CycIo
  } cyc_typ_t;

  typedef struct packed {
    logic [7:0]         base;
    logic [7:0]         mask;
    logic [MaxCntW-1:0] waits;
    logic               en;
  } iowin_cfg_t;

  // A mask bit of 1 means that address bit takes part in the compare.
  function automatic logic port_match(input logic [7:0] addr, input logic [7:0] base,
                                      input logic [7:0] mask);
    return ((addr ^ base) & mask) == 8'h00;
  endfunction

endpackage

// File: rtl/msx_wait_gen_if.sv
// Z80 bus strobes seen by the wait generator, plus its WAIT_n/busy outputs.
//   master : CPU/bus side (drives strobes, address, external wait request)
//   slave  : wait generator (samples strobes, drives wait_n and busy)
interface msx_wait_gen_if;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        rfrsh_n;
  logic [15:0] a;
  logic        exwait_n;
  logic        wait_n;
  logic        busy;

  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfrsh_n, a, exwait_n,
    input  wait_n, busy
  );

  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfrsh_n, a, exwait_n,
    output wait_n, busy
  );
endinterface

// File: rtl/msx_wait_iowin_match.sv
// Combinational I/O window matcher.
//   addr_i  : I/O port (a[7:0])
//   cfg_i   : N_IOWIN window configurations
//   hit_o   : some enabled window matches
//   waits_o : wait count of the lowest-index matching window (0 when no hit)
module msx_wait_iowin_match
  import msx_wait_pkg::*;
#(
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned N_IOWIN = 4
) (
  input  logic [7:0]       addr_i,
  input  iowin_cfg_t       cfg_i [N_IOWIN],
  output logic             hit_o,
  output logic [CNT_W-1:0] waits_o
);

  // Scan from the top so the lowest matching index is the last to write.
  always_comb begin
    hit_o   = 1'b0;
    waits_o = '0;
    for (int i = int'(N_IOWIN) - 1; i >= 0; i--) begin
      if (cfg_i[i].en && port_match(addr_i, cfg_i[i].base, cfg_i[i].mask)) begin
        hit_o   = 1'b1;
        waits_o = cfg_i[i].waits[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/msx_wait_gen.sv
// Programmable Z80 wait-state generator for the MSX core.
//   clk21m, reset_n : system clock, synchronous active-low reset
//   ce_3m58_p       : CPU clock enable; the FSM advances only on it
//   bus             : strobes/address/exwait_n in, wait_n (registered) and busy out
//   m1_waits, mem_waits                    : waits for opcode fetch / other memory cycles
//   iowin_base/mask/waits/en (packed, N_IOWIN fields) : I/O wait windows
//   stats_cnt       : inserted wait ticks, saturating (built only with MSX_WAIT_STATS_EN,
//                     otherwise constant 0)
module msx_wait_gen
  import msx_wait_pkg::*;
#(
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned N_IOWIN      = 4,
  parameter int unsigned M1_WAITS_RST = 1
) (
  input  logic                     clk21m,
  input  logic                     reset_n,
  input  logic                     ce_3m58_p,
  msx_wait_gen_if.slave            bus,
  input  logic [CNT_W-1:0]         m1_waits,
  input  logic [CNT_W-1:0]         mem_waits,
  input  logic [N_IOWIN*8-1:0]     iowin_base,
  input  logic [N_IOWIN*8-1:0]     iowin_mask,
  input  logic [N_IOWIN*CNT_W-1:0] iowin_waits,
  input  logic [N_IOWIN-1:0]       iowin_en,
  output logic [15:0]              stats_cnt
);

  if (CNT_W == 0 || CNT_W > MaxCntW) begin : g_bad_cnt_w
    $error("CNT_W out of range");
  end
  // M1_WAITS_RST is the value the config register feeding m1_waits resets to.
  if (M1_WAITS_RST >= (1 << CNT_W)) begin : g_bad_m1_rst
    $error("M1_WAITS_RST does not fit in CNT_W bits");
  end

  wait_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_n_q, wait_n_d;

  logic             unused_addr_hi;
  assign unused_addr_hi = ^bus.a[15:8];

  // I/O window matching
  iowin_cfg_t       win_cfg [N_IOWIN];
  logic             win_hit;
  logic [CNT_W-1:0] win_waits;

  always_comb begin
    for (int unsigned i = 0; i < N_IOWIN; i++) begin
      win_cfg[i].base  = iowin_base[i*8 +: 8];
      win_cfg[i].mask  = iowin_mask[i*8 +: 8];
      win_cfg[i].waits = MaxCntW'(iowin_waits[i*CNT_W +: CNT_W]);
      win_cfg[i].en    = iowin_en[i];
    end
  end

  msx_wait_iowin_match #(
    .CNT_W  (CNT_W),
    .N_IOWIN(N_IOWIN)
  ) u_iowin_match (
    .addr_i (bus.a[7:0]),
    .cfg_i  (win_cfg),
    .hit_o  (win_hit),
    .waits_o(win_waits)
  );

  // Cycle classifier. Refresh and interrupt acknowledge are tested first so
  // they never fall into the memory/IO branches.
  cyc_typ_t         cyc_typ;
  logic             cyc_start;
  logic             rw_act;
  logic [CNT_W-1:0] cyc_waits;

  assign rw_act = ~bus.rd_n | ~bus.wr_n;

  always_comb begin
    cyc_typ   = CycNone;
    cyc_start = 1'b0;
    if (!bus.rfrsh_n || (!bus.iorq_n && !bus.m1_n)) begin
      cyc_start = 1'b1;
    end else if (!bus.mreq_n && !bus.m1_n) begin
      cyc_typ   = CycFetch;
      cyc_start = 1'b1;
    end else if (!bus.mreq_n && rw_act) begin
      cyc_typ   = CycMem;
      cyc_start = 1'b1;
    end else if (!bus.iorq_n && rw_act) begin
      cyc_typ   = CycIo;
      cyc_start = 1'b1;
    end

    unique case (cyc_typ)
      CycFetch: cyc_waits = m1_waits;
      CycMem:   cyc_waits = mem_waits;
      CycIo:    cyc_waits = win_hit ? win_waits : '0;
      default:  cyc_waits = '0;
    endcase
  end

  logic bus_idle;
  assign bus_idle = bus.mreq_n & bus.iorq_n;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_n_d = wait_n_q;
    if (ce_3m58_p) begin
      unique case (state_q)
        StIdle: begin
          if (cyc_start) begin
            if (cyc_typ == CycNone) begin
              state_d = StHold;
            end else if (cyc_waits != '0) begin
              wait_n_d = 1'b0;
              cnt_d    = cyc_waits;
              state_d  = StCount;
            end else if (!bus.exwait_n) begin
              wait_n_d = 1'b0;
              state_d  = StExt;
            end else begin
              state_d = StHold;
            end
          end
        end
        StCount: begin
          if (bus_idle) begin
            wait_n_d = 1'b1;
            cnt_d    = '0;
            state_d  = StIdle;
          end else if (cnt_q == CNT_W'(1)) begin
            cnt_d = '0;
            // Going straight to EXT keeps wait_n low with no release glitch.
            if (!bus.exwait_n) begin
              state_d = StExt;
            end else begin
              wait_n_d = 1'b1;
              state_d  = StHold;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StExt: begin
          if (bus_idle) begin
            wait_n_d = 1'b1;
            state_d  = StIdle;
          end else if (bus.exwait_n) begin
            wait_n_d = 1'b1;
            state_d  = StHold;
          end
        end
        StHold: begin
          if (bus_idle) state_d = StIdle;
        end
        default: begin
          wait_n_d = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk21m) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wait_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_n_q <= wait_n_d;
    end
  end

  assign bus.wait_n = wait_n_q;
  assign bus.busy   = (state_q != StIdle);

`ifdef MSX_WAIT_STATS_EN
  logic [15:0] stats_q, stats_d;

  always_comb begin
    stats_d = stats_q;
    if (ce_3m58_p && !wait_n_q && stats_q != 16'hFFFF) stats_d = stats_q + 16'd1;
  end

  always_ff @(posedge clk21m) begin
    if (!reset_n) stats_q <= '0;
    else          stats_q <= stats_d;
  end

  assign stats_cnt = stats_q;
`else
  assign stats_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_msx_wait_gen.sv
module tb_msx_wait_gen;

  logic        clk21m = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_3m58_p = 1'b0;
  logic [2:0]  m1_waits;
  logic [2:0]  mem_waits;
  logic [31:0] iowin_base;
  logic [31:0] iowin_mask;
  logic [11:0] iowin_waits;
  logic [3:0]  iowin_en;
  logic [15:0] stats_cnt;

  int checks = 0;
  int errors = 0;
  int div = 0;

  msx_wait_gen_if bus ();

  msx_wait_gen #(
    .CNT_W       (3),
    .N_IOWIN     (4),
    .M1_WAITS_RST(1)
  ) dut (
    .clk21m     (clk21m),
    .reset_n    (reset_n),
    .ce_3m58_p  (ce_3m58_p),
    .bus        (bus),
    .m1_waits   (m1_waits),
    .mem_waits  (mem_waits),
    .iowin_base (iowin_base),
    .iowin_mask (iowin_mask),
    .iowin_waits(iowin_waits),
    .iowin_en   (iowin_en),
    .stats_cnt  (stats_cnt)
  );

  always #5 clk21m = ~clk21m;

  // One enable every six system clocks.
  always @(posedge clk21m) begin
    div       <= (div == 5) ? 0 : div + 1;
    ce_3m58_p <= (div == 5);
  end

  // Advance to just after the next clock edge on which the DUT saw ce high.
  task automatic tick();
    int guard = 0;
    do begin
      @(posedge clk21m);
      guard++;
    end while (ce_3m58_p !== 1'b1 && guard < 20);
    if (ce_3m58_p !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no clock enable within %0d clocks", guard);
    end
    #1;
  endtask

  // Tick n times, counting ticks with wait_n low, high-to-low edges, and first low tick.
  task automatic run_ticks(input int n, output int lows, output int falls, output int first_low);
    logic prev;
    lows      = 0;
    falls     = 0;
    first_low = -1;
    prev      = bus.wait_n;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bus.wait_n === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = k;
        if (prev === 1'b1) falls++;
      end
      prev = bus.wait_n;
    end
  endtask

  task automatic bus_release();
    bus.m1_n     = 1'b1;
    bus.mreq_n   = 1'b1;
    bus.iorq_n   = 1'b1;
    bus.rd_n     = 1'b1;
    bus.wr_n     = 1'b1;
    bus.rfrsh_n  = 1'b1;
    bus.exwait_n = 1'b1;
  endtask

  task automatic end_cycle();
    bus_release();
    tick();
    tick();
  endtask

  task automatic start_fetch();
    bus.a = 16'h0100; bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
  endtask

  task automatic start_mem_rd();
    bus.a = 16'h8000; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
  endtask

  task automatic start_io_wr(input logic [7:0] port);
    bus.a = {8'h00, port}; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk21m);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus_release();
    bus.a       = 16'h0000;
    m1_waits    = 3'd1;
    mem_waits   = 3'd0;
    iowin_base  = '0;
    iowin_mask  = '0;
    iowin_waits = '0;
    iowin_en    = '0;
    do_reset();
    checks++;
    if (bus.wait_n !== 1'b1) begin
      errors++; $display("FAIL reset_wait_n: got %b want 1", bus.wait_n);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (stats_cnt !== 16'h0000) begin
      errors++; $display("FAIL reset_stats: got %h want 0000", stats_cnt);
    end
  endtask

  task automatic test_fetch_default();
    int lows, falls, first;
    start_fetch();
    run_ticks(6, lows, falls, first);
    checks++;
    if (lows !== 1 || first !== 1) begin
      errors++; $display("FAIL fetch_m1_1: got lows=%0d first=%0d want 1/1", lows, first);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL fetch_busy_hold: got %b want 1", bus.busy);
    end
    end_cycle();
    checks++;
    if (bus.busy !== 1'b0 || bus.wait_n !== 1'b1) begin
      errors++; $display("FAIL fetch_end: got busy=%b wait_n=%b want 0/1", bus.busy, bus.wait_n);
    end
    m1_waits = 3'd7;
    start_fetch();
    run_ticks(10, lows, falls, first);
    checks++;
    if (lows !== 7 || falls !== 1) begin
      errors++; $display("FAIL fetch_m1_max: got lows=%0d falls=%0d want 7/1", lows, falls);
    end
    end_cycle();
    m1_waits = 3'd1;
  endtask

  task automatic test_mem();
    int lows, falls, first, lows2;
    mem_waits = 3'd3;
    start_mem_rd();
    run_ticks(8, lows, falls, first);
    checks++;
    if (lows !== 3 || first !== 1) begin
      errors++; $display("FAIL mem_3: got lows=%0d first=%0d want 3/1", lows, first);
    end
    end_cycle();
    mem_waits = 3'd0;
    start_mem_rd();
    run_ticks(6, lows, falls, first);
    checks++;
    if (lows !== 0) begin
      errors++; $display("FAIL mem_0: got lows=%0d want 0", lows);
    end
    end_cycle();
    // Config changed after the cycle started must not matter.
    mem_waits = 3'd3;
    start_mem_rd();
    run_ticks(1, lows, falls, first);
    mem_waits = 3'd7;
    run_ticks(9, lows2, falls, first);
    checks++;
    if (lows + lows2 !== 3) begin
      errors++; $display("FAIL mem_cfg_midcycle: got lows=%0d want 3", lows + lows2);
    end
    end_cycle();
    mem_waits = 3'd0;
  endtask

  task automatic test_iowin();
    int lows, falls, first;
    iowin_base  = {8'h00, 8'h00, 8'h98, 8'h98};
    iowin_mask  = {8'h00, 8'h00, 8'hFF, 8'hFC};
    iowin_waits = {3'd0, 3'd0, 3'd5, 3'd2};
    iowin_en    = 4'b0011;
    start_io_wr(8'h99);
    run_ticks(8, lows, falls, first);
    checks++;
    if (lows !== 2) begin
      errors++; $display("FAIL io_win0_prio: got lows=%0d want 2", lows);
    end
    end_cycle();
    iowin_en = 4'b0010;
    start_io_wr(8'h98);
    run_ticks(8, lows, falls, first);
    checks++;
    if (lows !== 5) begin
      errors++; $display("FAIL io_win1: got lows=%0d want 5", lows);
    end
    end_cycle();
    start_io_wr(8'hA0);
    run_ticks(6, lows, falls, first);
    checks++;
    if (lows !== 0) begin
      errors++; $display("FAIL io_nomatch: got lows=%0d want 0", lows);
    end
    end_cycle();
    // Interrupt acknowledge at a matching address gets no wait.
    bus.a = 16'h0098; bus.iorq_n = 1'b0; bus.m1_n = 1'b0;
    run_ticks(6, lows, falls, first);
    checks++;
    if (lows !== 0) begin
      errors++; $display("FAIL io_intack: got lows=%0d want 0", lows);
    end
    end_cycle();
    iowin_en = 4'b0000;
  endtask

  task automatic test_exwait();
    int lows, falls, first, lows2, falls2;
    m1_waits     = 3'd2;
    start_fetch();
    bus.exwait_n = 1'b0;
    run_ticks(6, lows, falls, first);
    bus.exwait_n = 1'b1;
    run_ticks(4, lows2, falls2, first);
    checks++;
    if (lows + lows2 !== 6 || falls + falls2 !== 1) begin
      errors++;
      $display("FAIL exwait_extend: got lows=%0d falls=%0d want 6/1", lows + lows2, falls + falls2);
    end
    end_cycle();
    // Zero-wait cycle stretched only by the external request.
    start_mem_rd();
    bus.exwait_n = 1'b0;
    run_ticks(2, lows, falls, first);
    bus.exwait_n = 1'b1;
    run_ticks(4, lows2, falls2, first);
    checks++;
    if (lows + lows2 !== 2) begin
      errors++; $display("FAIL exwait_zero_count: got lows=%0d want 2", lows + lows2);
    end
    end_cycle();
    // Refresh ignores the external request.
    bus.mreq_n = 1'b0; bus.rfrsh_n = 1'b0; bus.exwait_n = 1'b0;
    run_ticks(4, lows, falls, first);
    checks++;
    if (lows !== 0) begin
      errors++; $display("FAIL refresh_nowait: got lows=%0d want 0", lows);
    end
    end_cycle();
    m1_waits = 3'd1;
  endtask

  task automatic test_abort();
    int lows, falls, first;
    m1_waits = 3'd5;
    start_fetch();
    run_ticks(2, lows, falls, first);
    bus_release();
    tick();
    checks++;
    if (lows !== 2 || bus.wait_n !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: got lows=%0d wait_n=%b busy=%b want 2/1/0", lows, bus.wait_n, bus.busy);
    end
    tick();
    m1_waits = 3'd1;
  endtask

  task automatic test_reset_mid();
    int lows, falls, first;
    m1_waits = 3'd5;
    start_fetch();
    run_ticks(2, lows, falls, first);
    reset_n = 1'b0;
    @(posedge clk21m);
    #1;
    checks++;
    if (bus.wait_n !== 1'b1 || bus.busy !== 1'b0 || stats_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: got wait_n=%b busy=%b stats=%h want 1/0/0000",
               bus.wait_n, bus.busy, stats_cnt);
    end
    bus_release();
    @(posedge clk21m);
    #1;
    reset_n  = 1'b1;
    m1_waits = 3'd1;
  endtask

  task automatic test_stats();
    int lows, falls, first;
    logic [15:0] exp;
    do_reset();
    m1_waits = 3'd1;
    for (int n = 0; n < 10; n++) begin
      start_fetch();
      run_ticks(3, lows, falls, first);
      end_cycle();
    end
    iowin_base  = {8'h00, 8'h10, 8'h00, 8'h00};
    iowin_mask  = {8'h00, 8'hFF, 8'h00, 8'h00};
    iowin_waits = {3'd0, 3'd4, 3'd0, 3'd0};
    iowin_en    = 4'b0100;
    start_io_wr(8'h10);
    run_ticks(6, lows, falls, first);
    end_cycle();
`ifdef MSX_WAIT_STATS_EN
    exp = 16'd14;
`else
    exp = 16'd0;
`endif
    checks++;
    if (stats_cnt !== exp) begin
      errors++; $display("FAIL stats_count: got %0d want %0d", stats_cnt, exp);
    end
`ifdef MSX_WAIT_STATS_EN
    force dut.stats_q = 16'hFFFE;
    @(posedge clk21m);
    #1;
    release dut.stats_q;
    m1_waits = 3'd3;
    start_fetch();
    run_ticks(5, lows, falls, first);
    end_cycle();
    checks++;
    if (stats_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL stats_saturate: got %h want ffff", stats_cnt);
    end
    m1_waits = 3'd1;
`endif
  endtask

  initial begin
    test_reset();
    test_fetch_default();
    test_mem();
    test_iowin();
    test_exwait();
    test_abort();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
